cmp_serial: RTL and testbench

Parametrised, multi-cycle magnitude/equality comparator for two W-bit operands, signed or unsigned. It compares C bits per clock, starting with the most significant chunk, and terminates early at the first chunk that differs. It is the sequential, area-lean successor to the single-bit equality cells. It serves datapaths that can tolerate variable latency in exchange for a narrow compare slice, and uses a start/ready/done handshake.

---
 rtl/cmp_pkg.sv | 22 ++
 rtl/cmp_chunk.sv | 17 +
 rtl/cmp_serial.sv | 126 ++++++++++++
 tb/tb_cmp_serial.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude/equality comparator.
package cmp_pkg;

   // Controller states.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   // Result codes as reported by eq/gt/lt.
   typedef enum logic [1:0] {
      RES_EQ = 2'd0,
      RES_GT = 2'd1,
      RES_LT = 2'd2
   } res_t;

   // Width of the chunk index counter; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational C-bit unsigned compare slice: equality and greater-than.
module cmp_chunk #(
   parameter int unsigned C = 4
) (
   input  logic [C-1:0] i_a,
   input  logic [C-1:0] i_b,
   output logic         o_eq,
   output logic         o_gt
);

   // Single narrow compare; the wide compare is built up over cycles by the top.
   always_comb begin
      o_eq = (i_a == i_b);
      o_gt = (i_a > i_b);
   end

endmodule

// File: rtl/cmp_serial.sv
// Multi-cycle comparator: walks operands MSB chunk first, stops at the first
// chunk that differs. Signed operands are mapped to offset binary on capture.
module cmp_serial
   import cmp_pkg::*;
#(
   parameter int unsigned W = 16,
   parameter int unsigned C = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         is_signed,
   output logic         ready,
   output logic         done,
   output logic         eq,
   output logic         gt,
   output logic         lt
);

   localparam int unsigned N  = W / C;
   localparam int unsigned KW = cnt_width(N);

   state_t        r_state;
   logic [KW-1:0] r_k;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic          r_ready;
   logic          r_done;
   logic          r_eq;
   logic          r_gt;
   logic          r_lt;

   logic [W-1:0]  w_sign_mask;
   logic [C-1:0]  w_ca;
   logic [C-1:0]  w_cb;
   logic          w_ceq;
   logic          w_cgt;

   // Flipping the sign bit of both operands turns a signed compare into an
   // unsigned one, so every chunk compare downstream stays unsigned.
   always_comb begin
      w_sign_mask      = '0;
      w_sign_mask[W-1] = is_signed;
   end

   // Select chunk k of both operands for the shared compare slice.
   always_comb begin
      w_ca = '0;
      w_cb = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (r_k == KW'(i)) begin
            w_ca = r_a[i*C +: C];
            w_cb = r_b[i*C +: C];
         end
      end
   end

   cmp_chunk #(
      .C (C)
   ) u_chunk (
      .i_a  (w_ca),
      .i_b  (w_cb),
      .o_eq (w_ceq),
      .o_gt (w_cgt)
   );

   // Controller: capture on start, step through chunks, register the verdict.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_k     <= KW'(N - 1);
         r_a     <= '0;
         r_b     <= '0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_eq    <= 1'b0;
         r_gt    <= 1'b0;
         r_lt    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a ^ w_sign_mask;
                  r_b     <= b ^ w_sign_mask;
                  r_k     <= KW'(N - 1);
                  r_ready <= 1'b0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (!w_ceq) begin
                  r_eq    <= 1'b0;
                  r_gt    <= w_cgt;
                  r_lt    <= ~w_cgt;
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end else if (r_k == '0) begin
                  r_eq    <= 1'b1;
                  r_gt    <= 1'b0;
                  r_lt    <= 1'b0;
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_k <= r_k - 1'b1;
               end
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready = r_ready;
   assign done  = r_done;
   assign eq    = r_eq;
   assign gt    = r_gt;
   assign lt    = r_lt;

endmodule

// File: tb/tb_cmp_serial.sv
// Directed bench for cmp_serial with a cycle-level reference model.
module tb_cmp_serial;
   import cmp_pkg::*;

   localparam int W = 16;
   localparam int C = 4;
   localparam int N = W / C;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          is_signed;
   logic          ready;
   logic          done;
   logic          eq;
   logic          gt;
   logic          lt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   cmp_serial #(
      .W (W),
      .C (C)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .ready     (ready),
      .done      (done),
      .eq        (eq),
      .gt        (gt),
      .lt        (lt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Cycles from accepted start to done: position of the most significant
   // differing bit decides which chunk settles the compare.
   function automatic int lat_of(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      d = x ^ y;
      if (d == '0) return N;
      for (int i = W - 1; i >= 0; i--)
         if (d[i]) return N - i / C;
      return N;
   endfunction

   // {eq,gt,lt} straight from integer comparison.
   function automatic logic [2:0] res_of(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
      if (x == y) return 3'b100;
      if (s) return ($signed(x) > $signed(y)) ? 3'b010 : 3'b001;
      return (x > y) ? 3'b010 : 3'b001;
   endfunction

   function automatic logic [2:0] code_bits(input res_t c);
      case (c)
         RES_EQ:  return 3'b100;
         RES_GT:  return 3'b010;
         RES_LT:  return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   // Reference model
   logic       m_busy;
   int         m_cnt;
   logic       m_ready;
   logic       m_done;
   logic [2:0] m_res;
   logic [2:0] m_pend;

   always @(posedge clk) begin
      if (reset) begin
         m_busy  <= 1'b0;
         m_cnt   <= 0;
         m_ready <= 1'b1;
         m_done  <= 1'b0;
         m_res   <= 3'b000;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_cnt == 1) begin
               m_busy  <= 1'b0;
               m_done  <= 1'b1;
               m_ready <= 1'b1;
               m_res   <= m_pend;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end else if (start) begin
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
            m_cnt   <= lat_of(a, b);
            m_pend  <= res_of(a, b, is_signed);
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", 32'(ready), 32'(m_ready));
         chk("done", 32'(done), 32'(m_done));
         chk("result", 32'({eq, gt, lt}), 32'(m_res));
      end
   end

   // One compare with literal latency/result; b2b starts in the current cycle.
   task automatic run(input logic [W-1:0] va, input logic [W-1:0] vb, input logic s,
                      input int exp_lat, input res_t exp_code, input bit b2b,
                      input bit noise, input string name);
      int n;
      if (!b2b) begin
         @(posedge clk);
         #1;
      end
      chk({name, "_rdy"}, 32'(ready), 32'd1);
      start = 1'b1; a = va; b = vb; is_signed = s;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (noise) begin
         start = 1'b1; a = ~va; b = ~vb; is_signed = ~s;
      end
      n = 1;
      while (!done && n < 20) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         n++;
      end
      start = 1'b0;
      chk({name, "_lat"}, 32'(n), 32'(exp_lat));
      chk({name, "_res"}, 32'({eq, gt, lt}), 32'(code_bits(exp_code)));
   endtask

   initial begin
      int seen;
      reset = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_res", 32'({eq, gt, lt}), 32'd0);
      chk_en = 1'b1;

      // Pin the model to hand-worked values.
      chk("model_lat_eq", 32'(lat_of(16'h1234, 16'h1234)), 32'd4);
      chk("model_lat_c2", 32'(lat_of(16'h1334, 16'h1234)), 32'd2);
      chk("model_res_s", 32'(res_of(16'hFFFF, 16'h0000, 1'b1)), 32'b001);

      run(16'h1234, 16'h1234, 1'b0, 5, RES_EQ, 1'b0, 1'b0, "eq");
      run(16'h8000, 16'h7FFF, 1'b0, 2, RES_GT, 1'b0, 1'b0, "msb_u");
      run(16'h8000, 16'h7FFF, 1'b1, 2, RES_LT, 1'b0, 1'b0, "msb_s");
      run(16'h1334, 16'h1234, 1'b0, 3, RES_GT, 1'b0, 1'b0, "chunk2");
      run(16'h1233, 16'h1234, 1'b0, 5, RES_LT, 1'b0, 1'b0, "lsb");
      run(16'hFFFF, 16'h0000, 1'b1, 2, RES_LT, 1'b0, 1'b0, "neg_s");
      run(16'hFFFF, 16'h0000, 1'b0, 2, RES_GT, 1'b0, 1'b0, "neg_u");
      run(16'hABC5, 16'hABC5, 1'b1, 5, RES_EQ, 1'b0, 1'b0, "eq_s");
      run(16'h1254, 16'h1234, 1'b1, 4, RES_GT, 1'b0, 1'b0, "chunk3");

      // Start pulses while busy must be ignored.
      run(16'h1234, 16'h1234, 1'b0, 5, RES_EQ, 1'b0, 1'b1, "busy_start");

      // Back-to-back: new start issued in the done cycle.
      run(16'h1233, 16'h1234, 1'b0, 5, RES_LT, 1'b0, 1'b0, "b2b_first");
      run(16'h8000, 16'h7FFF, 1'b1, 2, RES_LT, 1'b1, 1'b0, "b2b_second");
      run(16'h0001, 16'h0000, 1'b0, 5, RES_GT, 1'b1, 1'b0, "b2b_third");

      // Reset during BUSY aborts and clears results.
      @(posedge clk);
      #1;
      start = 1'b1; a = 16'h1234; b = 16'h1234; is_signed = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_busy", 32'(ready), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_res", 32'({eq, gt, lt}), 32'd0);
      seen = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      chk("abort_nodone", 32'(seen), 32'd0);

      run(16'h7FFF, 16'h8000, 1'b1, 2, RES_GT, 1'b0, 1'b0, "post_abort");

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
